cory_demux: RTL and testbench

CORY_DEMUX -- requirements
Module: cory_demux

---
 rtl/cory_demux.sv | 66 ++++++
 tb/tb_cory_demux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cory_demux.sv
// rtl/cory_demux.sv - one-to-R stream demultiplexer with a single holding slot per output port
// A beat is routed by i_a_s into that port's slot; out-of-range selects are accepted and dropped.
module cory_demux #(
  parameter int N = 8,
  parameter int R = 2,
  parameter int S = 1,
  parameter int D = R*N
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  input  logic [S-1:0] i_a_s,
  output logic         o_a_r,
  output logic [R-1:0] o_zx_v,
  output logic [D-1:0] o_zx_d,
  input  logic [R-1:0] i_zx_r,
  output logic         o_drop
);

  logic [R-1:0]        slot_v;
  logic [R-1:0][N-1:0] slot_d;
  logic [R-1:0]        load;
  logic                in_range;

  assign in_range = ({1'b0, i_a_s} < (S+1)'(R));

  // Ready only looks at the addressed slot, so a stalled port never blocks the others.
  always_comb begin
    o_a_r = 1'b1;
    for (int k = 0; k < R; k++) begin
      if (reset_n && (i_a_s == S'(k))) begin
        o_a_r = !slot_v[k] || i_zx_r[k];
      end
    end
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < R; k++) begin
      load[k] = reset_n && i_a_v && o_a_r && (i_a_s == S'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_v <= '0;
      slot_d <= '0;
      o_drop <= 1'b0;
    end else begin
      for (int k = 0; k < R; k++) begin
        if (load[k]) begin
          slot_v[k] <= 1'b1;
          slot_d[k] <= i_a_d;
        end else if (i_zx_r[k]) begin
          slot_v[k] <= 1'b0;
        end
      end
      o_drop <= i_a_v && !in_range;
    end
  end

  assign o_zx_v = slot_v;
  assign o_zx_d = slot_d;

endmodule

// File: tb/tb_cory_demux.sv
// tb/tb_cory_demux.sv - directed and scoreboard bench for cory_demux
// Drives a 4-port and a 3-port instance from shared input beats.
module tb_cory_demux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_v;
  logic [7:0]  a_d;
  logic [1:0]  a_s;

  logic [3:0]  zx_r4;
  logic        ar4, drop4;
  logic [3:0]  zv4;
  logic [31:0] zd4;

  logic [2:0]  zx_r3;
  logic        ar3, drop3;
  logic [2:0]  zv3;
  logic [23:0] zd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cory_demux #(.N(8), .R(4), .S(2), .D(32)) dut4 (
    .clk(clk), .reset_n(reset_n), .i_a_v(a_v), .i_a_d(a_d), .i_a_s(a_s),
    .o_a_r(ar4), .o_zx_v(zv4), .o_zx_d(zd4), .i_zx_r(zx_r4), .o_drop(drop4)
  );

  cory_demux #(.N(8), .R(3), .S(2), .D(24)) dut3 (
    .clk(clk), .reset_n(reset_n), .i_a_v(a_v), .i_a_d(a_d), .i_a_s(a_s),
    .o_a_r(ar3), .o_zx_v(zv3), .o_zx_d(zd3), .i_zx_r(zx_r3), .o_drop(drop3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-port scoreboard for the 3-port instance; each queue holds at most one beat.
  logic [7:0] exp_q [3][$];
  int   exp_drops, act_drops;
  logic drop_exp;
  logic [7:0] seq;
  logic exp_ar;

  initial begin
    reset_n = 1'b0;
    a_v = 1'b0; a_d = 8'h00; a_s = 2'd0;
    zx_r4 = 4'hF; zx_r3 = 3'h7;

    // reset state
    tick(); tick();
    #1;
    check("rst_zv4", 32'(zv4), 32'h0);
    check("rst_zd4", zd4, 32'h0);
    check("rst_drop4", 32'(drop4), 32'h0);
    check("rst_ar4", 32'(ar4), 32'h1);
    reset_n = 1'b1;
    tick();

    // basic route to port 2
    a_v = 1'b1; a_s = 2'd2; a_d = 8'hA5; #1;
    check("route_ar", 32'(ar4), 32'h1);
    tick();
    a_v = 1'b0; #1;
    check("route_zv", 32'(zv4), 32'h4);
    check("route_zd", 32'(zd4[23:16]), 32'hA5);
    check("route_ar_after", 32'(ar4), 32'h1);
    tick();
    check("route_drained", 32'(zv4), 32'h0);

    // backpressure on port 1, bypass to port 3
    a_v = 1'b1; a_s = 2'd1; a_d = 8'h11;
    tick();
    zx_r4 = 4'b1101; a_d = 8'h22; #1;
    check("bp_ar_stalled", 32'(ar4), 32'h0);
    tick();
    check("bp_zv1", 32'(zv4[1]), 32'h1);
    check("bp_hold", 32'(zd4[15:8]), 32'h11);
    a_s = 2'd3; a_d = 8'h33; #1;
    check("bp_ar_other", 32'(ar4), 32'h1);
    tick();
    a_v = 1'b0; #1;
    check("bp_zv_both", 32'(zv4), 32'hA);
    check("bp_zd3", 32'(zd4[31:24]), 32'h33);
    check("bp_zd1_still", 32'(zd4[15:8]), 32'h11);
    zx_r4 = 4'hF;
    tick();
    check("bp_drained", 32'(zv4), 32'h0);

    // streaming four beats to port 0
    for (int i = 1; i <= 4; i++) begin
      a_v = 1'b1; a_s = 2'd0; a_d = 8'(i);
      tick();
      check("stream_zv", 32'(zv4), 32'h1);
      check("stream_zd", 32'(zd4[7:0]), 32'(i));
    end
    a_v = 1'b0;
    tick();
    check("stream_end", 32'(zv4), 32'h0);

    // reset mid-stream with ports 0 and 2 held
    zx_r4 = 4'h0;
    a_v = 1'b1; a_s = 2'd0; a_d = 8'h40; tick();
    a_s = 2'd2; a_d = 8'h42; tick();
    a_v = 1'b0; #1;
    check("mid_held", 32'(zv4), 32'h5);
    reset_n = 1'b0; a_v = 1'b1; a_s = 2'd0; a_d = 8'h99;
    tick();
    reset_n = 1'b1; a_v = 1'b0; #1;
    check("mid_rst_zv", 32'(zv4), 32'h0);
    check("mid_rst_zd", zd4, 32'h0);
    check("mid_rst_drop", 32'(drop4), 32'h0);
    a_v = 1'b1; a_s = 2'd0; a_d = 8'h77; #1;
    check("mid_ar", 32'(ar4), 32'h1);
    tick();
    a_v = 1'b0; #1;
    check("mid_after_zv", 32'(zv4), 32'h1);
    check("mid_after_zd", 32'(zd4[7:0]), 32'h77);
    zx_r4 = 4'hF;
    tick(); tick();

    // invalid port on the 3-port instance
    zx_r3 = 3'h7;
    a_v = 1'b1; a_s = 2'd3; a_d = 8'h5A; #1;
    check("inv_ar", 32'(ar3), 32'h1);
    tick();
    a_v = 1'b0; #1;
    check("inv_drop", 32'(drop3), 32'h1);
    check("inv_zv", 32'(zv3), 32'h0);
    tick();
    check("inv_drop_clear", 32'(drop3), 32'h0);

    // random traffic against the scoreboard
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    exp_drops = 0; act_drops = 0; drop_exp = 1'b0; seq = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      check("rnd_drop", 32'(drop3), 32'(drop_exp));
      if (drop3) act_drops++;
      for (int k = 0; k < 3; k++)
        check("rnd_zv", 32'(zv3[k]), 32'(exp_q[k].size() != 0));
      a_v = 1'($urandom_range(0, 1));
      a_s = 2'($urandom_range(0, 3));
      a_d = seq;
      zx_r3 = 3'($urandom_range(0, 7));
      #1;
      exp_ar = (a_s == 2'd3) || (exp_q[a_s].size() == 0) || zx_r3[a_s];
      check("rnd_ar", 32'(ar3), 32'(exp_ar));
      for (int k = 0; k < 3; k++) begin
        if (zv3[k] && zx_r3[k]) begin
          if (exp_q[k].size() == 0) check("rnd_extra", 32'(zd3[k*8 +: 8]), 32'hFFFF_FFFF);
          else check("rnd_data", 32'(zd3[k*8 +: 8]), 32'(exp_q[k].pop_front()));
        end
      end
      drop_exp = 1'b0;
      if (a_v && exp_ar) begin
        if (a_s == 2'd3) begin
          drop_exp = 1'b1;
          exp_drops++;
        end else begin
          exp_q[a_s].push_back(a_d);
        end
        seq++;
      end
      tick();
    end
    a_v = 1'b0; zx_r3 = 3'h7;
    check("rnd_drop_last", 32'(drop3), 32'(drop_exp));
    if (drop3) act_drops++;
    for (int k = 0; k < 3; k++) begin
      if (zv3[k]) begin
        if (exp_q[k].size() == 0) check("rnd_tail_extra", 32'(zd3[k*8 +: 8]), 32'hFFFF_FFFF);
        else check("rnd_tail", 32'(zd3[k*8 +: 8]), 32'(exp_q[k].pop_front()));
      end
    end
    tick();
    check("rnd_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'h0);
    check("rnd_drops", 32'(act_drops), 32'(exp_drops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
